// File: rtl/flexsoc_pkg.sv
// Shared types for the FlexSoC reset sequencer.
//   rst_state_e  : sequencer state (PO_WAIT -> SYS_HOLD -> RUN)
//   CAUSE_*      : bit positions inside the sticky RST_CAUSE register
package flexsoc_pkg;

    typedef enum logic [1:0] {
        PO_WAIT  = 2'd0,   // power-on reset held, waiting for lock + PO_CYCLES
        SYS_HOLD = 2'd1,   // power-on released, system reset held SYS_CYCLES
        RUN      = 2'd2    // everything released
    } rst_state_e;

    localparam int CAUSE_BTN    = 0;
    localparam int CAUSE_LOCK   = 1;
    localparam int CAUSE_SYSREQ = 2;
    localparam int CAUSE_HOST   = 3;

endpackage

// File: rtl/flexsoc_sync2.sv
// Generic two-flop synchroniser for a single-bit asynchronous level.
//   clk_i : destination clock
//   rst_i : async active-high reset, clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronised output (two clk_i cycles of latency)
module flexsoc_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/flexsoc_rst_ctrl.sv
// Reset sequencer for the FlexSoC FPGA top (hclk domain).
// Releases PORESETn once both PLLs are locked for PO_CYCLES, then HRESETn
// SYS_CYCLES later. In RUN, a filtered PLL lock loss replays the full
// sequence; a core or host request replays only the system reset.
//   CLK          : hclk
//   RESET        : async active-high pushbutton reset
//   HPLL_LOCKED  : async HCLK PLL lock
//   TPLL_LOCKED  : async transport PLL lock
//   SYSRESETREQ  : core system reset request (level)
//   HOST_RST_REQ : host system reset request (single-cycle pulse)
//   CAUSE_CLR    : clears RST_CAUSE
//   PORESETn     : power-on reset, active-low
//   HRESETn      : system reset, active-low
//   RST_CAUSE    : sticky {host, sysreq, lock, button}
//   RST_BUSY     : high while either reset output is asserted
module flexsoc_rst_ctrl
    import flexsoc_pkg::*;
#(
    parameter int PO_CYCLES   = 15,
    parameter int SYS_CYCLES  = 8,
    parameter int LOCK_FILTER = 4,
    parameter int CTR_W       = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       HPLL_LOCKED,
    input  logic       TPLL_LOCKED,
    input  logic       SYSRESETREQ,
    input  logic       HOST_RST_REQ,
    input  logic       CAUSE_CLR,
    output logic       PORESETn,
    output logic       HRESETn,
    output logic [3:0] RST_CAUSE,
    output logic       RST_BUSY
);

    localparam int FLT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [CTR_W-1:0] PO_LAST  = CTR_W'(PO_CYCLES - 1);
    localparam logic [CTR_W-1:0] SYS_LAST = CTR_W'(SYS_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_MAX  = FLT_W'(LOCK_FILTER);

    // ------------------------------------------------------------------
    // Lock synchronisation and loss filter
    // ------------------------------------------------------------------
    logic hlock_s;
    logic tlock_s;
    logic lock_s;

    flexsoc_sync2 u_sync_hpll (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (HPLL_LOCKED),
        .q_o   (hlock_s)
    );

    flexsoc_sync2 u_sync_tpll (
        .clk_i (CLK),
        .rst_i (RESET),
        .d_i   (TPLL_LOCKED),
        .q_o   (tlock_s)
    );

    assign lock_s = hlock_s & tlock_s;

    // Starts saturated so lock_lost reads true until the PLLs are seen locked.
    logic [FLT_W-1:0] filt_q;
    logic             lock_lost;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            filt_q <= FLT_MAX;
        end else if (lock_s) begin
            filt_q <= '0;
        end else if (filt_q != FLT_MAX) begin
            filt_q <= filt_q + FLT_W'(1);
        end
    end

    assign lock_lost = (filt_q == FLT_MAX);

    // ------------------------------------------------------------------
    // Cause bits raised this cycle; only events seen in RUN count.
    // ------------------------------------------------------------------
    rst_state_e state_q;
    logic [3:0] cause_set;

    always_comb begin
        cause_set = '0;
        if (state_q == RUN) begin
            if (lock_lost) begin
                cause_set[CAUSE_LOCK] = 1'b1;
            end else begin
                cause_set[CAUSE_SYSREQ] = SYSRESETREQ;
                cause_set[CAUSE_HOST]   = HOST_RST_REQ;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: every output is a flop updated alongside the state.
    // ------------------------------------------------------------------
    logic [CTR_W-1:0] cnt_q;
    logic             po_q;
    logic             hr_q;
    logic             busy_q;
    logic [3:0]       cause_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= PO_WAIT;
            cnt_q   <= '0;
            po_q    <= 1'b0;
            hr_q    <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= 4'b0001;
        end else begin
            // Clear first so a same-cycle set event survives for its bit.
            cause_q <= (CAUSE_CLR ? 4'b0000 : cause_q) | cause_set;

            case (state_q)
                PO_WAIT: begin
                    if (!lock_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == PO_LAST) begin
                        state_q <= SYS_HOLD;
                        cnt_q   <= '0;
                        po_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CTR_W'(1);
                    end
                end

                SYS_HOLD: begin
                    if (lock_lost) begin
                        state_q <= PO_WAIT;
                        cnt_q   <= '0;
                        po_q    <= 1'b0;
                        hr_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (cnt_q == SYS_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        hr_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CTR_W'(1);
                    end
                end

                RUN: begin
                    if (lock_lost) begin
                        state_q <= PO_WAIT;
                        cnt_q   <= '0;
                        po_q    <= 1'b0;
                        hr_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (SYSRESETREQ || HOST_RST_REQ) begin
                        state_q <= SYS_HOLD;
                        cnt_q   <= '0;
                        hr_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= PO_WAIT;
                    cnt_q   <= '0;
                    po_q    <= 1'b0;
                    hr_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign PORESETn  = po_q;
    assign HRESETn   = hr_q;
    assign RST_BUSY  = busy_q;
    assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_flexsoc_rst_ctrl.sv
module tb_flexsoc_rst_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       HPLL_LOCKED = 1'b1;
    logic       TPLL_LOCKED = 1'b1;
    logic       SYSRESETREQ = 1'b0;
    logic       HOST_RST_REQ = 1'b0;
    logic       CAUSE_CLR = 1'b0;
    logic       PORESETn;
    logic       HRESETn;
    logic [3:0] RST_CAUSE;
    logic       RST_BUSY;

    flexsoc_rst_ctrl dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .HPLL_LOCKED  (HPLL_LOCKED),
        .TPLL_LOCKED  (TPLL_LOCKED),
        .SYSRESETREQ  (SYSRESETREQ),
        .HOST_RST_REQ (HOST_RST_REQ),
        .CAUSE_CLR    (CAUSE_CLR),
        .PORESETn     (PORESETn),
        .HRESETn      (HRESETn),
        .RST_CAUSE    (RST_CAUSE),
        .RST_BUSY     (RST_BUSY)
    );

    always #5 CLK = ~CLK;

    // Expected values are pushed when stimulus is applied, popped on observation.
    int exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Ticks until the selected output reaches lvl; 0=PORESETn, 1=HRESETn.
    // Returns 200 when the bound expires, which never matches an expectation.
    task automatic wait_sig(input int which, input logic lvl, output int n);
        logic v;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            v = (which == 0) ? PORESETn : HRESETn;
            if (v === lvl) break;
        end
    endtask

    // Full reset and release with both PLLs locked, ending in RUN.
    task automatic bring_up;
        int n;
        SYSRESETREQ = 0; HOST_RST_REQ = 0; CAUSE_CLR = 0;
        HPLL_LOCKED = 1; TPLL_LOCKED = 1;
        RESET = 1;
        tick(); tick();
        RESET = 0;
        wait_sig(1, 1'b1, n);
    endtask

    task automatic test_reset;
        int n, e;
        RESET = 1; HPLL_LOCKED = 1; TPLL_LOCKED = 1;
        tick(); tick();
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
        e = exp_q.pop_front(); n_cmp++;
        if (PORESETn !== e[0]) begin n_err++; $display("FAIL rst_po: got %b want %0d", PORESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (HRESETn !== e[0]) begin n_err++; $display("FAIL rst_hr: got %b want %0d", HRESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_BUSY !== e[0]) begin n_err++; $display("FAIL rst_busy: got %b want %0d", RST_BUSY, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL rst_cause: got %b want %b", RST_CAUSE, e[3:0]); end

        // 2 sync cycles + PO_CYCLES to PORESETn, then SYS_CYCLES to HRESETn.
        RESET = 0;
        exp_q.push_back(17); exp_q.push_back(8); exp_q.push_back(0); exp_q.push_back(1);
        wait_sig(0, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL rel_po_lat: got %0d want %0d", n, e); end
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL rel_hr_lat: got %0d want %0d", n, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_BUSY !== e[0]) begin n_err++; $display("FAIL rel_busy: got %b want %0d", RST_BUSY, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL rel_cause: got %b want %b", RST_CAUSE, e[3:0]); end
    endtask

    task automatic test_lock_wait;
        int n, e;
        RESET = 1; HPLL_LOCKED = 1; TPLL_LOCKED = 0;
        tick();
        RESET = 0;
        repeat (10) tick();
        exp_q.push_back(0); exp_q.push_back(1);
        e = exp_q.pop_front(); n_cmp++;
        if (PORESETn !== e[0]) begin n_err++; $display("FAIL nolock_po: got %b want %0d", PORESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_BUSY !== e[0]) begin n_err++; $display("FAIL nolock_busy: got %b want %0d", RST_BUSY, e); end

        TPLL_LOCKED = 1;
        exp_q.push_back(17); exp_q.push_back(8);
        wait_sig(0, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL lockw_po_lat: got %0d want %0d", n, e); end
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL lockw_hr_lat: got %0d want %0d", n, e); end
    endtask

    task automatic test_lock_glitch;
        int n, e, bad;
        // Short glitch: filter peaks at 3, nothing should move.
        HPLL_LOCKED = 0;
        repeat (3) tick();
        HPLL_LOCKED = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (PORESETn !== 1'b1 || HRESETn !== 1'b1) bad++;
        end
        exp_q.push_back(0);
        e = exp_q.pop_front(); n_cmp++;
        if (bad !== e) begin n_err++; $display("FAIL short_glitch: got %0d disturbed cycles want %0d", bad, e); end

        // Long drop: lock_lost registers after 6 cycles, PO_WAIT one cycle later.
        HPLL_LOCKED = 0;
        repeat (6) tick();
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(4'b0011);
        exp_q.push_back(16); exp_q.push_back(8);
        e = exp_q.pop_front(); n_cmp++;
        if (PORESETn !== e[0]) begin n_err++; $display("FAIL loss_po_early: got %b want %0d", PORESETn, e); end
        HPLL_LOCKED = 1;
        tick();
        e = exp_q.pop_front(); n_cmp++;
        if (PORESETn !== e[0]) begin n_err++; $display("FAIL loss_po: got %b want %0d", PORESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL loss_cause: got %b want %b", RST_CAUSE, e[3:0]); end
        wait_sig(0, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL relock_po_lat: got %0d want %0d", n, e); end
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL relock_hr_lat: got %0d want %0d", n, e); end
    endtask

    task automatic test_dual_req;
        int n, e, po_low;
        bring_up();
        SYSRESETREQ = 1; HOST_RST_REQ = 1;
        tick();
        SYSRESETREQ = 0; HOST_RST_REQ = 0;
        exp_q.push_back(0); exp_q.push_back(8); exp_q.push_back(0); exp_q.push_back(4'b1101);
        e = exp_q.pop_front(); n_cmp++;
        if (HRESETn !== e[0]) begin n_err++; $display("FAIL dual_hr_low: got %b want %0d", HRESETn, e); end
        po_low = 0;
        n = 0;
        while (n < 200 && HRESETn !== 1'b1) begin
            tick(); n++;
            if (PORESETn !== 1'b1) po_low++;
        end
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL dual_hr_len: got %0d want %0d", n, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (po_low !== e) begin n_err++; $display("FAIL dual_po_stable: got %0d low cycles want %0d", po_low, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL dual_cause: got %b want %b", RST_CAUSE, e[3:0]); end
    endtask

    task automatic test_async_reset_clr;
        int n, e;
        SYSRESETREQ = 1;
        tick();
        SYSRESETREQ = 0;
        tick();
        // Mid-cycle assertion: outputs must drop before the next edge.
        #2 RESET = 1;
        #1;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4'b0001);
        e = exp_q.pop_front(); n_cmp++;
        if (PORESETn !== e[0]) begin n_err++; $display("FAIL async_po: got %b want %0d", PORESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (HRESETn !== e[0]) begin n_err++; $display("FAIL async_hr: got %b want %0d", HRESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_BUSY !== e[0]) begin n_err++; $display("FAIL async_busy: got %b want %0d", RST_BUSY, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL async_cause: got %b want %b", RST_CAUSE, e[3:0]); end

        tick();
        RESET = 0;
        exp_q.push_back(25);
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL async_rel_lat: got %0d want %0d", n, e); end

        CAUSE_CLR = 1;
        tick();
        CAUSE_CLR = 0;
        exp_q.push_back(4'b0000);
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL clr_cause: got %b want %b", RST_CAUSE, e[3:0]); end

        CAUSE_CLR = 1; SYSRESETREQ = 1;
        tick();
        CAUSE_CLR = 0; SYSRESETREQ = 0;
        exp_q.push_back(4'b0100); exp_q.push_back(8);
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL clr_set_cause: got %b want %b", RST_CAUSE, e[3:0]); end
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL clr_set_hr_len: got %0d want %0d", n, e); end
    endtask

    task automatic test_req_in_hold;
        int n, e;
        CAUSE_CLR = 1;
        tick();
        CAUSE_CLR = 0;
        HOST_RST_REQ = 1;
        tick();
        HOST_RST_REQ = 0;
        tick();
        SYSRESETREQ = 1;
        repeat (3) tick();
        exp_q.push_back(4'b1000); exp_q.push_back(4);
        exp_q.push_back(0); exp_q.push_back(4'b1100); exp_q.push_back(8); exp_q.push_back(0);
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL hold_ignore_cause: got %b want %b", RST_CAUSE, e[3:0]); end
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL hold_hr_lat: got %0d want %0d", n, e); end
        // Request still high on RUN entry re-triggers the system reset.
        tick();
        SYSRESETREQ = 0;
        e = exp_q.pop_front(); n_cmp++;
        if (HRESETn !== e[0]) begin n_err++; $display("FAIL retrig_hr: got %b want %0d", HRESETn, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_CAUSE !== e[3:0]) begin n_err++; $display("FAIL retrig_cause: got %b want %b", RST_CAUSE, e[3:0]); end
        wait_sig(1, 1'b1, n);
        e = exp_q.pop_front(); n_cmp++;
        if (n !== e) begin n_err++; $display("FAIL retrig_hr_len: got %0d want %0d", n, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (RST_BUSY !== e[0]) begin n_err++; $display("FAIL retrig_busy: got %b want %0d", RST_BUSY, e); end
    endtask

    initial begin
        test_reset();
        test_lock_wait();
        test_lock_glitch();
        test_dual_req();
        test_async_reset_clr();
        test_req_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
